// File: rtl/pkg_control_gray.sv
// Shared types and helpers for the Gray switch sampling controller.
// Holds the FSM state enum, data/anode widths and a 4-bit popcount.
package pkg_control_gray;

  localparam int ANCHO_GRAY = 4;
  localparam int NUM_ANODOS = 8;

  typedef enum logic [1:0] {
    IDLE,
    VERIFICAR,
    ACEPTAR
  } estado_t;

  function automatic logic [2:0] popcount4(
    input logic [3:0] v
  );
    popcount4 = 3'(v[0]) + 3'(v[1])
              + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running prescaler: counts 0..DIV-1 and wraps.
// Ports: clk, reset (async, active-low), tick (high when count is DIV-1).
module divisor_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] ULT = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (cnt == ULT)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == ULT);

endmodule

// File: rtl/control_muestreo_gray.sv
// Syncs/debounces 4 Gray switches, strobes stable values, flags jumps, scans digits.
// Ports: clk, reset(n), a, limpiar_error -> dato_gray, cargar, error_salto, digito_sel, anodo, led_reset.
module control_muestreo_gray
  import pkg_control_gray::*;
#(
  parameter int SAMPLE_DIV    = 100000,
  parameter int DEBOUNCE_N    = 8,
  parameter int SCAN_DIV      = 100000,
  parameter int ACTIVE_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ANCHO_GRAY-1:0] a,
  input  logic                  limpiar_error,
  output logic [ANCHO_GRAY-1:0] dato_gray,
  output logic                  cargar,
  output logic                  error_salto,
  output logic [2:0]            digito_sel,
  output logic [NUM_ANODOS-1:0] anodo,
  output logic                  led_reset
);

  localparam int DCW = $clog2(DEBOUNCE_N + 1);
  localparam logic [DCW-1:0] ULT_CNT = DCW'(DEBOUNCE_N - 1);
  localparam logic [2:0] ULT_DIG = 3'(ACTIVE_DIGITS - 1);
  localparam logic [NUM_ANODOS-1:0] UNO = NUM_ANODOS'(1);

  logic                  tick_m;
  logic                  tick_s;
  logic [ANCHO_GRAY-1:0] a_meta;
  logic [ANCHO_GRAY-1:0] a_sync;
  logic [ANCHO_GRAY-1:0] candidato;
  logic [DCW-1:0]        cnt;
  estado_t               estado;
  estado_t               estado_sig;
  logic                  salto;
  logic [2:0]            sel_sig;

  divisor_tick #(.DIV(SAMPLE_DIV)) u_div_muestreo (
    .clk  (clk),
    .reset(reset),
    .tick (tick_m)
  );

  divisor_tick #(.DIV(SCAN_DIV)) u_div_barrido (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_meta    <= '0;
      a_sync    <= '0;
      led_reset <= 1'b1;
    end else begin
      a_meta    <= a;
      a_sync    <= a_meta;
      led_reset <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      estado <= IDLE;
    else
      estado <= estado_sig;
  end

  // candidato never equals dato_gray while in VERIFICAR,
  // so the two match arms below are mutually exclusive.
  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE: begin
        if (tick_m && (a_sync != dato_gray))
          estado_sig = (DEBOUNCE_N == 1) ? ACEPTAR
                                         : VERIFICAR;
      end
      VERIFICAR: begin
        if (tick_m) begin
          unique case (1'b1)
            (a_sync == candidato): begin
              if (cnt == ULT_CNT)
                estado_sig = ACEPTAR;
            end
            (a_sync == dato_gray): estado_sig = IDLE;
            default: estado_sig = VERIFICAR;
          endcase
        end
      end
      ACEPTAR: estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_comb begin
    cargar = (estado == ACEPTAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      candidato <= '0;
      cnt       <= '0;
      dato_gray <= '0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (tick_m && (a_sync != dato_gray)) begin
            candidato <= a_sync;
            cnt       <= DCW'(1);
          end
        end
        VERIFICAR: begin
          if (tick_m) begin
            if (a_sync == candidato) begin
              cnt <= cnt + DCW'(1);
            end else if (a_sync != dato_gray) begin
              candidato <= a_sync;
              cnt       <= DCW'(1);
            end
          end
        end
        ACEPTAR: dato_gray <= candidato;
        default: cnt <= '0;
      endcase
    end
  end

  // dato_gray still holds the old value during ACEPTAR.
  assign salto = (estado == ACEPTAR) &&
                 (popcount4(candidato ^ dato_gray) > 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      error_salto <= 1'b0;
    else if (salto)
      error_salto <= 1'b1;
    else if (limpiar_error)
      error_salto <= 1'b0;
  end

  always_comb begin
    sel_sig = (digito_sel == ULT_DIG) ? 3'd0
                                      : digito_sel + 3'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digito_sel <= 3'd0;
      anodo      <= ~UNO;
    end else if (tick_s) begin
      digito_sel <= sel_sig;
      anodo      <= ~(UNO << sel_sig);
    end
  end

endmodule

// File: doc/control_muestreo_gray.md
Name: control_muestreo_gray

Overview:
- Sequencing controller placed in front of the Gray decoder datapath on the 100 MHz board clock.
- Synchronizes and debounces the 4 raw Gray switch inputs, then hands the decoder one stable value with a single-cycle load strobe.
- Flags illegal Gray transitions, i.e. accepted values that differ by more than one bit.
- Schedules the 7-segment digit scan (anode select) that the decoder's cathode logic follows.

Parameters:
- SAMPLE_DIV, 100000: clock cycles per sample tick (1 kHz at 100 MHz); must be >= 2.
- DEBOUNCE_N, 8: consecutive equal sample ticks required to accept a new value; must be >= 1.
- SCAN_DIV, 100000: clock cycles per digit-scan step; must be >= 2.
- ACTIVE_DIGITS, 2: number of digits scanned, 1..8; the remaining anodes stay off.

Ports:
- clk  in  1  board clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- a  in  4  raw Gray-code switch inputs, asynchronous to clk.
- limpiar_error  in  1  synchronous clear of error_salto.
- dato_gray  out  4  last accepted stable Gray value.
- cargar  out  1  one-cycle strobe when dato_gray updates.
- error_salto  out  1  sticky flag for an illegal Gray jump.
- digito_sel  out  3  index of the currently active digit.
- anodo  out  8  active-low one-hot anode drive.
- led_reset  out  1  reset indicator.

Behaviour:
- Reset is asynchronous and active-low. While reset=0:
  - dato_gray=0, cargar=0, error_salto=0, digito_sel=0, anodo=8'hFE, led_reset=1.
  - FSM is in IDLE; all counters, the candidate register and the synchronizer flops are 0.
- led_reset goes to 0 on the first clk rising edge after reset deasserts.
- Synchronizer: a two-flop chain produces a_sync. There is no other combinational path from a.
- Sample prescaler: counts 0..SAMPLE_DIV-1 and wraps. tick is high for exactly the one cycle where count == SAMPLE_DIV-1.
- FSM states and transitions (all evaluated only on tick, except ACEPTAR):
  - IDLE: if a_sync != dato_gray, load candidato<=a_sync, set cnt=1, go to VERIFICAR. Otherwise stay.
  - VERIFICAR, a_sync == candidato: cnt++. When cnt reaches DEBOUNCE_N, go to ACEPTAR.
  - VERIFICAR, a_sync == dato_gray (bounce back to the old value): go to IDLE with no strobe.
  - VERIFICAR, any other value: candidato<=a_sync, cnt=1, stay in VERIFICAR.
  - ACEPTAR lasts exactly one clk cycle, independent of tick. In that cycle: dato_gray<=candidato, cargar=1. Next state is IDLE.
- With DEBOUNCE_N=1, acceptance occurs on the first tick that differs (IDLE goes straight to ACEPTAR).
- Latency from a stable input edge to cargar: 2 synchronizer cycles, plus the wait to the next tick, plus (DEBOUNCE_N-1) further ticks, plus 1 cycle.
- Error check, done in ACEPTAR: popcount(candidato XOR dato_gray_old) > 1 sets error_salto.
  - error_salto holds until limpiar_error=1.
  - If set and clear happen in the same cycle, set wins.
- Scan prescaler is independent of the sample prescaler. On each scan tick, digito_sel increments modulo ACTIVE_DIGITS (wrap to 0).
- anodo = ~(8'b1 << digito_sel), registered. Bits >= ACTIVE_DIGITS are always 1.
- Reset asserted mid-debounce aborts the debounce with no cargar pulse. After release the FSM restarts from IDLE with dato_gray=0.
- cargar never stays high for two consecutive cycles. No cargar is issued for a value equal to dato_gray.

Decomposition:
- Package pkg_control_gray holds:
  - the FSM state enum: IDLE, VERIFICAR, ACEPTAR;
  - the data width constant ANCHO_GRAY=4;
  - the digit count constant NUM_ANODOS=8;
  - a popcount4 function.
- Sub-module divisor_tick (parameter DIV; ports clk, reset, tick) is instantiated twice: once for sampling and once for scan.

Test Plan:
All scenarios use SAMPLE_DIV=4, DEBOUNCE_N=3, SCAN_DIV=5, ACTIVE_DIGITS=2.
- Reset: hold reset=0 for 3 cycles -> led_reset=1, anodo=8'hFE, dato_gray=0, cargar=0. One cycle after release -> led_reset=0.
- Clean step: a 0000->0001 held stable -> exactly one cargar pulse with dato_gray=4'b0001, error_salto=0; the pulse lands within 2+4+2*4+1 = 15 cycles.
- Bounce: a toggles 0001/0000 every tick for 10 ticks, then settles at 0000 -> no cargar; dato_gray stays at 0001 until 0000 has been stable for 3 ticks, then one cargar.
- Illegal jump: dato_gray=0000, then a=0111 held stable -> cargar with dato_gray=0111 and error_salto=1. Pulse limpiar_error -> 0. Set and clear in the same cycle -> stays 1.
- Scan: free-run 30 cycles -> anodo alternates FE, FD, FE, ... every 5 cycles; digito_sel follows 0, 1, 0, ...; anodo[7:2] is always 1.
- Reset mid-debounce: assert reset after 2 of 3 stable ticks -> no cargar. After release with a still changed -> full debounce restarts and produces one cargar.
